// File: rtl/rom_pkg.sv
// Shared definitions for the two-requester ROM read arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_pkg;

  localparam int ADR_W = 5;
  localparam int N_REQ = 2;

  localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant decision: a lone requester wins, a tie goes to the rr pointer.
// Latency: combinational.
// Backpressure: none; the caller only samples winner when it can grant.
module rr_arb2
  import rom_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             rr,
  output logic [N_REQ-1:0] winner
);

  // One-hot winner; all-zero when nobody is requesting.
  always_comb begin
    winner = '0;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = rr ? 2'b10 : 2'b01;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/rom_read_arb.sv
// Arbitrates two requesters for a ROM and streams each winner's address segment.
// Latency: grant one enabled edge after req, then one word per enabled edge, done after the last word.
// Backpressure: enable stalls every state change; dropping req mid-segment aborts the transfer.
module rom_read_arb
  import rom_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req,
  input  logic [ADR_W-1:0]  start_adr0,
  input  logic [ADR_W-1:0]  start_adr1,
  input  logic [ADR_W-1:0]  adr_limit0,
  input  logic [ADR_W-1:0]  adr_limit1,
  input  logic [DATA_W-1:0] ROM_data,
  output logic [ADR_W-1:0]  ROM_adr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  done
);

  state_t           state;
  state_t           state_nxt;
  logic             rr;
  logic [ADR_W-1:0] limit;
  logic [N_REQ-1:0] winner;

  logic load;
  logic rd;
  logic inc;
  logic fin;
  logic abort;

  rr_arb2 u_arb (
    .req    (req),
    .rr     (rr),
    .winner (winner)
  );

  // Next-state and per-edge actions; nothing happens on disabled edges.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rd        = 1'b0;
    inc       = 1'b0;
    fin       = 1'b0;
    abort     = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            load      = 1'b1;
            state_nxt = READ;
          end
        end
        READ: begin
          // Owner withdrawing its request ends the segment silently.
          if ((req & grant) == '0) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end else begin
            rd = 1'b1;
            if (ROM_adr == limit) begin
              state_nxt = FINISH;
            end else begin
              inc = 1'b1;
            end
          end
        end
        FINISH: begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address counter, captured segment bounds, data capture, strobes and rr pointer.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ROM_adr    <= '0;
      limit      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      grant      <= '0;
      done       <= '0;
      rr         <= 1'b0;
    end else begin
      data_valid <= rd;
      done       <= fin ? grant : '0;
      if (load) begin
        ROM_adr <= winner[1] ? start_adr1 : start_adr0;
        limit   <= winner[1] ? adr_limit1 : adr_limit0;
        grant   <= winner;
      end
      if (rd) begin
        data_out <= ROM_data;
      end
      if (inc) begin
        ROM_adr <= ROM_adr + ADR_ONE;
      end
      if (abort || fin) begin
        grant <= '0;
      end
      // After serving requester 0, requester 1 gets the next tie, and vice versa.
      if (fin) begin
        rr <= grant[0];
      end
    end
  end

endmodule

// File: tb/tb_rom_read_arb.sv
// Directed and randomized bench for rom_read_arb against a word-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_read_arb;

  localparam int DW = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_DONE = 2;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    req;
  logic [4:0]    start_adr0, start_adr1, adr_limit0, adr_limit1;
  logic [DW-1:0] ROM_data;
  logic [4:0]    ROM_adr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [1:0]    grant, done;

  logic [DW-1:0] rom [32];

  int checks = 0;
  int errors = 0;

  // Reference model: which requester owns the ROM, how many words it is owed, how many delivered.
  int m_phase, m_owner, m_start, m_n, m_idx, m_rr;
  logic [4:0]    e_adr;
  logic [DW-1:0] e_data;
  logic          e_dv;
  logic [1:0]    e_grant, e_done;

  logic [DW-1:0] got_q[$];
  logic [1:0]    gq[$];
  logic [1:0]    prev_grant;
  logic          got_done;

  always #5 CLK = ~CLK;

  assign ROM_data = rom[ROM_adr];

  rom_read_arb #(.DATA_W(DW)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .start_adr0 (start_adr0),
    .start_adr1 (start_adr1),
    .adr_limit0 (adr_limit0),
    .adr_limit1 (adr_limit1),
    .ROM_data   (ROM_data),
    .ROM_adr    (ROM_adr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .grant      (grant),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_owner = 0; m_start = 0; m_n = 0; m_idx = 0; m_rr = 0;
    e_adr = '0; e_data = '0; e_dv = 1'b0; e_grant = '0; e_done = '0;
    prev_grant = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [4:0] st, lm;
    e_dv   = 1'b0;
    e_done = '0;
    if (!enable) return;
    case (m_phase)
      PH_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) m_owner = m_rr;
          else m_owner = req[1] ? 1 : 0;
          st = (m_owner == 1) ? start_adr1 : start_adr0;
          lm = (m_owner == 1) ? adr_limit1 : adr_limit0;
          m_start = int'(st);
          m_n     = ((int'(lm) - int'(st) + 32) % 32) + 1;
          m_idx   = 0;
          e_adr   = st;
          e_grant = 2'b01 << m_owner;
          m_phase = PH_BUSY;
        end
      end
      PH_BUSY: begin
        if (!req[m_owner]) begin
          e_grant = '0;
          m_phase = PH_IDLE;
        end else begin
          e_data = rom[(m_start + m_idx) % 32];
          e_dv   = 1'b1;
          m_idx++;
          if (m_idx == m_n) m_phase = PH_DONE;
          else e_adr = 5'((m_start + m_idx) % 32);
        end
      end
      default: begin
        e_done  = 2'b01 << m_owner;
        e_grant = '0;
        m_rr    = 1 - m_owner;
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check("ROM_adr", 32'(ROM_adr), 32'(e_adr));
    check("data_out", 32'(data_out), 32'(e_data));
    check("data_valid", 32'(data_valid), 32'(e_dv));
    check("grant", 32'(grant), 32'(e_grant));
    check("done", 32'(done), 32'(e_done));
    if (data_valid) got_q.push_back(data_out);
    if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
    prev_grant = grant;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_ROM_adr", 32'(ROM_adr), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic run_to_done(input int max_cyc, input bit keep_req);
    got_done = 1'b0;
    for (int n = 0; n < max_cyc && !got_done; n++) begin
      tick();
      if (e_done != 2'b00) begin
        got_done = 1'b1;
        if (!keep_req) req = req & ~e_done;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
    reset_n = 1'b0; enable = 1'b0; req = 2'b00;
    start_adr0 = '0; start_adr1 = '0; adr_limit0 = '0; adr_limit1 = '0;
    model_reset();
    do_reset();

    // Simple segment 3..6 on requester 0.
    enable = 1'b1; req = 2'b01; start_adr0 = 5'd3; adr_limit0 = 5'd6;
    got_q.delete();
    run_to_done(12, 1'b0);
    check("seg36_words", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("seg36_data", 32'(got_q[i]), 32'(rom[3 + i]));
    tick();

    // Both requesting from reset: 0,1,0,1.
    do_reset();
    req = 2'b11; start_adr0 = 5'd1; adr_limit0 = 5'd2; start_adr1 = 5'd10; adr_limit1 = 5'd11;
    gq.delete();
    for (int k = 0; k < 4; k++) run_to_done(10, 1'b1);
    req = 2'b00;
    tick();
    check("rr_order_len", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Wrapping segment 30..1 on requester 1.
    req = 2'b10; start_adr1 = 5'd30; adr_limit1 = 5'd1;
    got_q.delete();
    run_to_done(12, 1'b0);
    check("wrap_words", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("wrap_d0", 32'(got_q[0]), 32'(rom[30]));
      check("wrap_d1", 32'(got_q[1]), 32'(rom[31]));
      check("wrap_d2", 32'(got_q[2]), 32'(rom[0]));
      check("wrap_d3", 32'(got_q[3]), 32'(rom[1]));
    end
    check("wrap_done", 32'(done), 32'd2);

    // Single-word segment at 9.
    req = 2'b01; start_adr0 = 5'd9; adr_limit0 = 5'd9;
    got_q.delete();
    run_to_done(6, 1'b0);
    check("single_words", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("single_data", 32'(got_q[0]), 32'(rom[9]));

    // Abort requester 0 mid-segment; requester 1 then runs normally. Bounds change mid-read is ignored.
    req = 2'b01; start_adr0 = 5'd0; adr_limit0 = 5'd20;
    tick(); tick();
    start_adr0 = 5'd7; adr_limit0 = 5'd1;
    tick();
    req = 2'b10; start_adr1 = 5'd5; adr_limit1 = 5'd6;
    tick();
    check("abort_grant", 32'(grant), 32'd0);
    got_q.delete();
    run_to_done(8, 1'b0);
    check("after_abort_words", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) check("after_abort_d1", 32'(got_q[1]), 32'(rom[6]));

    // Enable toggling mid-read, then an asynchronous reset mid-read.
    req = 2'b01; start_adr0 = 5'd12; adr_limit0 = 5'd18;
    tick();
    for (int k = 0; k < 6; k++) begin
      enable = (k % 2 == 0);
      tick();
    end
    enable = 1'b1;
    tick();
    do_reset();
    req = 2'b00;
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      start_adr0 = 5'($urandom); adr_limit0 = 5'($urandom);
      start_adr1 = 5'($urandom); adr_limit1 = 5'($urandom);
      for (int b = 0; b < 2; b++) begin
        if (!req[b]) begin
          if ($urandom_range(0, 3) == 0) req[b] = 1'b1;
        end else if (e_done[b] && $urandom_range(0, 1) == 0) begin
          req[b] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[b] = 1'b0;
        end
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
